// File: rtl/bcd_conv_arbiter.sv
// Round-robin sequencer sharing one binary-to-BCD converter among NREQ requesters.
// Optional WAIT watchdog enabled by defining BCD_CONV_ARBITER_TIMEOUT_EN.
`timescale 1ns/1ps
module bcd_conv_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [13*NREQ-1:0]   bin_in,
  output logic [NREQ-1:0]      ack,
  output logic [15:0]          bcd_out,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 err,
  output logic                 cv_start,
  output logic [12:0]          cv_bin,
  input  logic                 cv_ready,
  input  logic                 cv_done_tick,
  input  logic [3:0]           cv_bcd3,
  input  logic [3:0]           cv_bcd2,
  input  logic [3:0]           cv_bcd1,
  input  logic [3:0]           cv_bcd0
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_param
    $error("bcd_conv_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t          state_r;
  state_t          state_s;
  logic [2:0]      rr_r;
  logic [2:0]      rr_next_s;
  logic [2:0]      sel_s;
  logic [2:0]      grant_id_r;
  logic [3:0]      cand_s;
  logic [7:0]      req_pad_s;
  logic [12:0]     opnd_s;
  logic [12:0]     cv_bin_r;
  logic [NREQ-1:0] ack_r;
  logic [NREQ-1:0] ack_set_s;
  logic [15:0]     bcd_out_r;
  logic            any_req_s;
  logic            finish_s;
  logic            timeout_s;

  // Round-robin pick: scan downward in rotation order so the last hit is the closest to rr_r.
  always_comb begin
    req_pad_s = 8'd0;
    req_pad_s[NREQ-1:0] = req;
    sel_s  = 3'd0;
    cand_s = 4'd0;
    opnd_s = 13'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s = {1'b0, rr_r} + 4'(k);
      cand_s = (cand_s >= 4'(NREQ)) ? (cand_s - 4'(NREQ)) : cand_s;
      sel_s  = req_pad_s[cand_s[2:0]] ? cand_s[2:0] : sel_s;
    end
    for (int k = 0; k < NREQ; k++) begin
      opnd_s = (sel_s == 3'(k)) ? bin_in[13*k +: 13] : opnd_s;
    end
    any_req_s = |req;
  end

  // One-hot ack pattern and next rotation start derived from the current grant.
  always_comb begin
    ack_set_s = {NREQ{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      ack_set_s[k] = (grant_id_r == 3'(k));
    end
    rr_next_s = (grant_id_r == 3'(NREQ - 1)) ? 3'd0 : (grant_id_r + 3'd1);
    finish_s  = cv_done_tick | timeout_s;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (any_req_s) begin
          state_s = S_LAUNCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LAUNCH: begin
        if (cv_ready) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_LAUNCH;
        end
      end
      S_WAIT: begin
        if (finish_s) begin
          state_s = S_RESP;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Grant/operand latch, result capture and rotation pointer update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_r       <= 3'd0;
      grant_id_r <= 3'd0;
      cv_bin_r   <= 13'd0;
      ack_r      <= {NREQ{1'b0}};
      bcd_out_r  <= 16'd0;
    end else begin
      ack_r <= {NREQ{1'b0}};
      if (state_r == S_IDLE && any_req_s) begin
        cv_bin_r   <= opnd_s;
        grant_id_r <= sel_s;
      end else begin
        cv_bin_r   <= cv_bin_r;
        grant_id_r <= grant_id_r;
      end
      if (state_r == S_WAIT && finish_s) begin
        ack_r     <= ack_set_s;
        bcd_out_r <= cv_done_tick ? {cv_bcd3, cv_bcd2, cv_bcd1, cv_bcd0} : 16'hFFFF;
      end else begin
        bcd_out_r <= bcd_out_r;
      end
      if (state_r == S_RESP) begin
        rr_r <= rr_next_s;
      end else begin
        rr_r <= rr_r;
      end
    end
  end

`ifdef BCD_CONV_ARBITER_TIMEOUT_EN
  logic [4:0] wd_cnt_r;
  logic       err_r;

  // Counter reaches TIMEOUT-1 in the TIMEOUT-th WAIT cycle, so the abort lands exactly there.
  assign timeout_s = (state_r == S_WAIT) && (wd_cnt_r == 5'(TIMEOUT - 1));
  assign err       = err_r;

  // Watchdog counter and sticky-until-next-ack error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_r <= 5'd0;
      err_r    <= 1'b0;
    end else begin
      if (state_r == S_LAUNCH) begin
        wd_cnt_r <= 5'd0;
      end else if (state_r == S_WAIT) begin
        wd_cnt_r <= wd_cnt_r + 5'd1;
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
      if (state_r == S_WAIT && cv_done_tick) begin
        err_r <= 1'b0;
      end else if (timeout_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  assign cv_start = (state_r == S_LAUNCH) && cv_ready;
  assign busy     = (state_r != S_IDLE);
  assign ack      = ack_r;
  assign bcd_out  = bcd_out_r;
  assign grant_id = grant_id_r;
  assign cv_bin   = cv_bin_r;

endmodule
